// File: rtl/sw_debounce_pkg.sv
// Shared constants for the switch input-conditioning stage and the MMIO bridge.
package sw_debounce_pkg;

    // Number of board DIP switches.
    localparam int SW_WIDTH        = 24;

    // Default debounce timing: one sample tick per 50000 clocks, 16 stable samples.
    localparam int DEF_TICK_DIV    = 50000;
    localparam int DEF_STABLE_CNT  = 16;
    localparam int DEF_SYNC_STAGES = 2;

    // MMIO addresses decoded by the data-memory bridge.
    localparam logic [31:0] MMIO_SW_LO_ADDR  = 32'hFFFF_F070; // sw[15:0]
    localparam logic [31:0] MMIO_SW_HI_ADDR  = 32'hFFFF_F072; // sw[23:16]
    localparam logic [31:0] MMIO_LED_LO_ADDR = 32'hFFFF_F060;
    localparam logic [31:0] MMIO_LED_HI_ADDR = 32'hFFFF_F062;

    // Width of a per-bit stability counter able to hold 0..stable.
    function automatic int cnt_width(input int stable);
        return (stable < 1) ? 1 : $clog2(stable + 1);
    endfunction

    // Width of the prescaler; at least one bit even when div is 1.
    function automatic int pre_width(input int div);
        return (div <= 1) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: synchronizer chain, stability counter and registered output.
// flip_o is high in the tick cycle whose edge will change sw_o.
module sw_debounce_bit
    import sw_debounce_pkg::*;
#(
    parameter int STABLE_CNT  = DEF_STABLE_CNT,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_raw,
    input  logic tick,
    output logic sw_o,
    output logic flip_o
);

    localparam int            CW       = cnt_width(STABLE_CNT);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   sw_q, sw_d;
    logic                   sync_sw;

    assign sync_sw = sync_q[SYNC_STAGES-1];
    assign sw_o    = sw_q;

    // Shift the raw pin through the synchronizer chain.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], sw_raw};
    end

    // Count consecutive differing samples; any matching sample aborts the flip.
    always_comb begin
        cnt_d  = cnt_q;
        sw_d   = sw_q;
        flip_o = 1'b0;
        if (tick) begin
            if (sync_sw == sw_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                sw_d   = sync_sw;
                cnt_d  = '0;
                flip_o = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt_q  <= '0;
            sw_q   <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            sw_q   <= sw_d;
        end
    end

endmodule

// File: rtl/sw_debounce.sv
// Synchronizes and debounces the board DIP switches for the MMIO bridge.
// Holds the sample-tick prescaler and the registered change pulse.
// Build option SW_DEBOUNCE_SIM_EN: drop the prescaler and tick every cycle.
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int WIDTH       = SW_WIDTH,
    parameter int TICK_DIV    = DEF_TICK_DIV,
    parameter int STABLE_CNT  = DEF_STABLE_CNT,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] device_sw,
    output logic             sw_changed,
    output logic             tick
);

    logic             tick_q, tick_d;
    logic [WIDTH-1:0] flip;
    logic             sw_changed_q, sw_changed_d;

    assign tick       = tick_q;
    assign sw_changed = sw_changed_q;

`ifdef SW_DEBOUNCE_SIM_EN
    // Fast-simulation build: sample on every cycle once out of reset.
    always_comb begin
        tick_d = 1'b1;
    end

    // Tick register; clears on reset, then stays high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick_d;
        end
    end
`else
    localparam int            PW       = pre_width(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] pre_q, pre_d;

    // Prescaler wraps at TICK_DIV-1; tick is registered and marks that count.
    always_comb begin
        pre_d  = (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);
        tick_d = (pre_d == PRE_LAST);
    end

    // Prescaler and tick registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            tick_q <= tick_d;
        end
    end
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sw_debounce_bit #(
            .STABLE_CNT  (STABLE_CNT),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_bit (
            .clk    (clk),
            .rst_n  (rst_n),
            .sw_raw (sw_raw[i]),
            .tick   (tick_q),
            .sw_o   (device_sw[i]),
            .flip_o (flip[i])
        );
    end

    // One pulse per flipping tick, however many bits flip together.
    always_comb begin
        sw_changed_d = |flip;
    end

    // Change-pulse register, aligned with the device_sw update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_changed_q <= 1'b0;
        end else begin
            sw_changed_q <= sw_changed_d;
        end
    end

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce (TICK_DIV=4, STABLE_CNT=3, SYNC_STAGES=2).
// Stimulus pushes expected {value, cycle} of each change pulse; a monitor pops and checks.
module tb_sw_debounce;

`ifdef SW_DEBOUNCE_SIM_EN
  localparam int TD = 1;
`else
  localparam int TD = 4;
`endif
  localparam int SC = 3;
  localparam int W  = 24;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [W-1:0] sw_raw = '0;
  logic [W-1:0] device_sw;
  logic         sw_changed;
  logic         tick;

  int           cyc = 0;
  int           rel = 0;
  int           total = 0;
  int           bad = 0;
  bit           done = 1'b0;
  bit           done_seen = 1'b0;
  logic [W-1:0] cur_exp = '0;

  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];

  sw_debounce #(
    .WIDTH       (W),
    .TICK_DIV    (TD),
    .STABLE_CNT  (SC),
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw_raw     (sw_raw),
    .device_sw  (device_sw),
    .sw_changed (sw_changed),
    .tick       (tick)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "watchdog expired");
  end

  // Sample edges after the last reset release fall on rel+TD, rel+2*TD, ...
  // Returns the n-th sample edge at or after edge 'from'.
  function automatic int nth_tick(input int from, input int n);
    int s;
    s = rel + TD;
    while (s < from) s += TD;
    return s + TD * (n - 1);
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [W-1:0] v, input int c);
    exp_q.push_back(v);
    exp_cyc_q.push_back(c);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) cycles(1);
    cycles(2);
  endtask

  // Clean change: raw captured next edge, sync valid two edges later, then SC samples.
  task automatic step(input logic [W-1:0] v);
    sw_raw = v;
    push(v, nth_tick(cyc + 3, SC));
    drain();
  endtask

  task automatic wait_phase(input int p);
    cycles(1);
    for (int i = 0; i < 16 && ((cyc - rel) % TD) != p; i++) cycles(1);
  endtask

  // scoreboard / monitor
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  initial begin : monitor
    logic [W-1:0] ev;
    int           ec;
    forever begin
      @(negedge clk or negedge rst_n);
      #1;
      if (!rst_n) begin
        cur_exp = '0;
        check("rst_device_sw", device_sw, '0);
        check("rst_sw_changed", W'(sw_changed), '0);
        check("rst_tick", W'(tick), '0);
      end else begin
        if (sw_changed) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_pulse: got pulse with device_sw=%h at cycle %0d, required none", device_sw, cyc);
          end else begin
            ev = exp_q.pop_front();
            ec = exp_cyc_q.pop_front();
            check("pulse_value", device_sw, ev);
            check("pulse_cycle", W'(cyc), W'(ec));
            cur_exp = ev;
          end
        end else if (exp_cyc_q.size() > 0 && cyc > exp_cyc_q[0]) begin
          total++;
          bad++;
          $display("FAIL missed_pulse: got no pulse by cycle %0d, required at cycle %0d", cyc, exp_cyc_q[0]);
          cur_exp = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
        end
        check("level_device_sw", device_sw, cur_exp);
        if (cyc > rel) check("tick", W'(tick), W'(((cyc - rel) % TD) == TD - 1));
      end
      if (done && !done_seen) begin
        done_seen = 1'b1;
        check("queue_empty", W'(exp_q.size()), '0);
      end
    end
  end

  // stimulus
  initial begin : stim
    int e0;
    int f;
    #1 rst_n = 1'b0;
    sw_raw = 24'hFFFFFF;

    // Reset held with all switches high; after release all bits flip on the 3rd tick.
    cycles(4);
    rst_n = 1'b1;
    rel = cyc;
    push(24'hFFFFFF, nth_tick(rel + 3, SC));
    drain();
    step(24'h000000);

    // Single bit rise and fall; other bits must stay 0.
    step(24'h000020);
    step(24'h000000);

`ifndef SW_DEBOUNCE_SIM_EN
    // Bounce on bit 0: high 6, low 2 (a tick lands in the low window), then steady high.
    wait_phase(TD - 1);
    e0 = cyc;
    sw_raw = 24'h000001;
    cycles(6);
    sw_raw = 24'h000000;
    cycles(2);
    sw_raw = 24'h000001;
    push(24'h000001, nth_tick(e0 + 11, SC));
    drain();
    step(24'h000000);
`endif

    // Multi-bit step: one pulse for all bits.
    step(24'hA5005A);
    step(24'h000000);

    // Async reset while the counters sit at 2; full debounce required after release.
    sw_raw = 24'h0F0000;
    f = nth_tick(cyc + 3, SC);
    for (int i = 0; i < 64 && cyc < f - (TD + 1) / 2; i++) cycles(1);
    #1 rst_n = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    rel = cyc;
    push(24'h0F0000, nth_tick(rel + 3, SC));
    drain();
    step(24'h000000);

`ifdef SW_DEBOUNCE_SIM_EN
    // Tick every cycle: bit 23 appears 2+3 cycles after capture.
    step(24'h800000);
`endif

    done = 1'b1;
    cycles(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
